// File: rtl/wb_slot_pkg.sv
// Shared definitions for the Wishbone slot router: FSM state encoding,
// CSR offsets within the CSR window, STATUS bit positions and the
// maximum number of downstream slots the router supports.
package wb_slot_pkg;

  localparam int MAX_SLOTS = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_FWD  = 2'd1,
    ST_CSR  = 2'd2,
    ST_RESP = 2'd3
  } state_e;

  localparam logic [31:0] CSR_ENABLE   = 32'h00;
  localparam logic [31:0] CSR_STATUS   = 32'h04;
  localparam logic [31:0] CSR_IRQ_EN   = 32'h08;
  localparam logic [31:0] CSR_CNT_BASE = 32'h10;

  localparam int STATUS_TO_BIT  = 0;
  localparam int STATUS_SLOT_LSB = 8;
  localparam int STATUS_SLOT_MSB = 10;

endpackage

// File: rtl/wb_slot_csr.sv
// Control/status registers of the slot router.
// Optional feature macro: WB_SLOT_TXN_COUNT_EN (per-slot 16-bit
// saturating counters of completed forwarded transactions).
// Ports:
//   clk, rst      clock, synchronous active-high reset
//   wr_en         write strobe (one cycle, from the router CSR state)
//   off           byte offset within the CSR window
//   wdata, sel    write data and byte enables
//   to_set        timeout event, to_slot = slot that timed out
//   cnt_inc       per-slot completed-transaction pulse
//   rdata         read mux output for off
//   enable        slot enables, zero-padded to MAX_SLOTS
//   irq           STATUS.TO & IRQ_EN
module wb_slot_csr
  import wb_slot_pkg::*;
#(
  parameter int NUM_SLOTS = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 wr_en,
  input  logic [31:0]          off,
  input  logic [31:0]          wdata,
  input  logic [3:0]           sel,
  input  logic                 to_set,
  input  logic [2:0]           to_slot,
  input  logic [MAX_SLOTS-1:0] cnt_inc,
  output logic [31:0]          rdata,
  output logic [MAX_SLOTS-1:0] enable,
  output logic                 irq
);

  logic [NUM_SLOTS-1:0] enable_q;
  logic                 to_q;
  logic [2:0]           slot_q;
  logic                 irq_en_q;
  logic [31:0]          cnt_rd;
  logic                 unused_wdata;

  assign unused_wdata = ^{wdata, sel[3:1]};

  always_ff @(posedge clk) begin
    if (rst) begin
      enable_q <= '1;
      to_q     <= 1'b0;
      slot_q   <= '0;
      irq_en_q <= 1'b0;
    end else begin
      if (wr_en && off == CSR_ENABLE && sel[0])
        enable_q <= wdata[NUM_SLOTS-1:0];
      if (wr_en && off == CSR_IRQ_EN && sel[0])
        irq_en_q <= wdata[0];
      // A timeout landing on the same edge as a W1C keeps TO set.
      if (to_set) begin
        to_q   <= 1'b1;
        slot_q <= to_slot;
      end else if (wr_en && off == CSR_STATUS && sel[0] && wdata[STATUS_TO_BIT]) begin
        to_q <= 1'b0;
      end
    end
  end

`ifdef WB_SLOT_TXN_COUNT_EN
  logic [15:0] cnt_q [NUM_SLOTS];
  logic        unused_cnt_inc;

  assign unused_cnt_inc = ^(cnt_inc >> NUM_SLOTS);

  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_SLOTS; i++) begin
      if (rst)
        cnt_q[i] <= '0;
      else if (wr_en && off == CSR_CNT_BASE + 32'(4 * i))
        cnt_q[i] <= '0;
      else if (cnt_inc[i] && cnt_q[i] != 16'hFFFF)
        cnt_q[i] <= cnt_q[i] + 16'd1;
    end
  end

  always_comb begin
    cnt_rd = '0;
    for (int i = 0; i < NUM_SLOTS; i++)
      if (off == CSR_CNT_BASE + 32'(4 * i))
        cnt_rd = {16'h0, cnt_q[i]};
  end
`else
  logic unused_cnt_inc;

  assign unused_cnt_inc = ^cnt_inc;
  assign cnt_rd = '0;
`endif

  always_comb begin
    rdata = '0;
    case (off)
      CSR_ENABLE: rdata = 32'(enable_q);
      CSR_STATUS: begin
        rdata[STATUS_TO_BIT]                   = to_q;
        rdata[STATUS_SLOT_MSB:STATUS_SLOT_LSB] = slot_q;
      end
      CSR_IRQ_EN: rdata = {31'h0, irq_en_q};
      default:    rdata = cnt_rd;
    endcase
  end

  assign enable = MAX_SLOTS'(enable_q);
  assign irq    = to_q & irq_en_q;

endmodule

// File: rtl/wb_slot_router.sv
// Wishbone front-end routing one classic-cycle transaction at a time from
// the user-area bus to NUM_SLOTS downstream slaves, with per-slot enables,
// an ack timeout that substitutes ERR_DATA, and a CSR window at index
// NUM_SLOTS. Optional feature macro: WB_SLOT_TXN_COUNT_EN (see wb_slot_csr).
// Ports:
//   wb_clk_i, wb_rst_i       clock, synchronous active-high reset
//   active                   router enable; gates all upstream outputs
//   wbs_*                    upstream Wishbone slave side
//   s_cyc_o, s_stb_o         per-slot cycle/strobe (one-hot or zero)
//   s_we_o/sel_o/adr_o/dat_o shared downstream request (zero when idle)
//   s_dat_i, s_ack_i         per-slot read data and acks
//   irq                      timeout interrupt (level)
//
// state | meaning
// IDLE  | waiting for a decoded request
// FWD   | request driven to one slot, timer running
// CSR   | local register access, one cycle
// RESP  | upstream ack for one cycle
module wb_slot_router
  import wb_slot_pkg::*;
#(
  parameter int          NUM_SLOTS  = 4,
  parameter logic [31:0] BASE_ADDR  = 32'h3000_0000,
  parameter int          SLOT_SHIFT = 8,
  parameter int          TIMEOUT    = 255,
  parameter logic [31:0] ERR_DATA   = 32'hDEAD_BEEF
) (
  input  logic                    wb_clk_i,
  input  logic                    wb_rst_i,
  input  logic                    active,
  input  logic                    wbs_cyc_i,
  input  logic                    wbs_stb_i,
  input  logic                    wbs_we_i,
  input  logic [3:0]              wbs_sel_i,
  input  logic [31:0]             wbs_adr_i,
  input  logic [31:0]             wbs_dat_i,
  output logic                    wbs_ack_o,
  output logic [31:0]             wbs_dat_o,
  output logic [NUM_SLOTS-1:0]    s_cyc_o,
  output logic [NUM_SLOTS-1:0]    s_stb_o,
  output logic                    s_we_o,
  output logic [3:0]              s_sel_o,
  output logic [SLOT_SHIFT-1:0]   s_adr_o,
  output logic [31:0]             s_dat_o,
  input  logic [32*NUM_SLOTS-1:0] s_dat_i,
  input  logic [NUM_SLOTS-1:0]    s_ack_i,
  output logic                    irq
);

  localparam logic [31:0] WIN_BYTES  = 32'(NUM_SLOTS + 1) << SLOT_SHIFT;
  localparam logic [31:0] OFF_MASK   = (32'd1 << SLOT_SHIFT) - 32'd1;
  localparam logic [15:0] TIMER_LAST = 16'(TIMEOUT - 1);
  localparam logic [MAX_SLOTS-1:0] ONE = {{(MAX_SLOTS-1){1'b0}}, 1'b1};

  state_e state_q, state_d;

  logic [31:0] rel_addr, slot_idx, csr_off;
  logic        hit, is_csr, req;
  logic [2:0]  idx3, slot_q;
  logic [15:0] timer_q;
  logic [31:0] resp_q, load_data, csr_rdata;
  logic        fwd_start, fwd_ack, fwd_to, csr_wr, load_en, csr_irq;

  logic [MAX_SLOTS-1:0] enable_pad, ack_pad, req_oh, cnt_inc;
  logic [31:0]          dat_arr [MAX_SLOTS];

  logic [NUM_SLOTS-1:0]  cyc_q;
  logic                  we_q;
  logic [3:0]            sel_q;
  logic [SLOT_SHIFT-1:0] adr_q;
  logic [31:0]           dat_q;

  // Unsigned offset from the base; anything below BASE_ADDR is excluded
  // explicitly since the subtraction wraps.
  assign rel_addr = wbs_adr_i - BASE_ADDR;
  assign hit      = (wbs_adr_i >= BASE_ADDR) && (rel_addr < WIN_BYTES);
  assign slot_idx = rel_addr >> SLOT_SHIFT;
  assign is_csr   = (slot_idx == 32'(NUM_SLOTS));
  assign idx3     = slot_idx[2:0];
  assign csr_off  = rel_addr & OFF_MASK;
  assign req      = active & wbs_cyc_i & wbs_stb_i & hit;
  assign req_oh   = ONE << idx3;
  assign cnt_inc  = fwd_ack ? (ONE << slot_q) : '0;

  // Pad slot-facing vectors to MAX_SLOTS so a 3-bit index is always in range.
  for (genvar g = 0; g < MAX_SLOTS; g++) begin : g_pad
    if (g < NUM_SLOTS) begin : g_live
      assign dat_arr[g] = s_dat_i[32*g +: 32];
      assign ack_pad[g] = s_ack_i[g];
    end else begin : g_tie
      assign dat_arr[g] = '0;
      assign ack_pad[g] = 1'b0;
    end
  end

  always_comb begin
    state_d   = state_q;
    fwd_start = 1'b0;
    fwd_ack   = 1'b0;
    fwd_to    = 1'b0;
    csr_wr    = 1'b0;
    load_en   = 1'b0;
    load_data = '0;
    case (state_q)
      ST_IDLE: begin
        if (req) begin
          if (is_csr) begin
            state_d = ST_CSR;
          end else if (enable_pad[idx3]) begin
            state_d   = ST_FWD;
            fwd_start = 1'b1;
          end else begin
            state_d = ST_RESP;
            load_en = 1'b1;
          end
        end
      end
      ST_FWD: begin
        // Ack is checked first so it wins over a coincident expiry.
        if (ack_pad[slot_q]) begin
          state_d   = ST_RESP;
          fwd_ack   = 1'b1;
          load_en   = 1'b1;
          load_data = dat_arr[slot_q];
        end else if (timer_q == TIMER_LAST) begin
          state_d   = ST_RESP;
          fwd_to    = 1'b1;
          load_en   = 1'b1;
          load_data = ERR_DATA;
        end
      end
      ST_CSR: begin
        state_d   = ST_RESP;
        csr_wr    = wbs_we_i;
        load_en   = 1'b1;
        load_data = csr_rdata;
      end
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    if (!active) begin
      state_d   = ST_IDLE;
      fwd_start = 1'b0;
      fwd_ack   = 1'b0;
      fwd_to    = 1'b0;
      csr_wr    = 1'b0;
      load_en   = 1'b0;
    end
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q <= ST_IDLE;
      resp_q  <= '0;
      slot_q  <= '0;
      timer_q <= '0;
      cyc_q   <= '0;
      we_q    <= 1'b0;
      sel_q   <= '0;
      adr_q   <= '0;
      dat_q   <= '0;
    end else begin
      state_q <= state_d;
      if (load_en)
        resp_q <= load_data;
      if (fwd_start) begin
        slot_q  <= idx3;
        timer_q <= '0;
        cyc_q   <= req_oh[NUM_SLOTS-1:0];
        we_q    <= wbs_we_i;
        sel_q   <= wbs_sel_i;
        adr_q   <= wbs_adr_i[SLOT_SHIFT-1:0];
        dat_q   <= wbs_dat_i;
      end else if (state_d != ST_FWD) begin
        cyc_q <= '0;
        we_q  <= 1'b0;
        sel_q <= '0;
        adr_q <= '0;
        dat_q <= '0;
      end else begin
        timer_q <= timer_q + 16'd1;
      end
    end
  end

  wb_slot_csr #(
    .NUM_SLOTS(NUM_SLOTS)
  ) u_csr (
    .clk    (wb_clk_i),
    .rst    (wb_rst_i),
    .wr_en  (csr_wr),
    .off    (csr_off),
    .wdata  (wbs_dat_i),
    .sel    (wbs_sel_i),
    .to_set (fwd_to),
    .to_slot(slot_q),
    .cnt_inc(cnt_inc),
    .rdata  (csr_rdata),
    .enable (enable_pad),
    .irq    (csr_irq)
  );

  assign wbs_ack_o = active && (state_q == ST_RESP);
  assign wbs_dat_o = wbs_ack_o ? resp_q : '0;
  assign irq       = active & csr_irq;
  assign s_cyc_o   = cyc_q;
  assign s_stb_o   = cyc_q;
  assign s_we_o    = we_q;
  assign s_sel_o   = sel_q;
  assign s_adr_o   = adr_q;
  assign s_dat_o   = dat_q;

endmodule

// File: tb/tb_wb_slot_router.sv
module tb_wb_slot_router;

  localparam int NS = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          active;
  logic          wbs_cyc_i, wbs_stb_i, wbs_we_i;
  logic [3:0]    wbs_sel_i;
  logic [31:0]   wbs_adr_i, wbs_dat_i;
  logic          wbs_ack_o;
  logic [31:0]   wbs_dat_o;
  logic [NS-1:0] s_cyc_o, s_stb_o;
  logic          s_we_o;
  logic [3:0]    s_sel_o;
  logic [7:0]    s_adr_o;
  logic [31:0]   s_dat_o;
  logic [32*NS-1:0] s_dat_i;
  logic [NS-1:0] s_ack_i;
  logic          irq;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  wb_slot_router #(
    .NUM_SLOTS(NS),
    .TIMEOUT  (8)
  ) dut (
    .wb_clk_i (clk),
    .wb_rst_i (rst),
    .active   (active),
    .wbs_cyc_i(wbs_cyc_i),
    .wbs_stb_i(wbs_stb_i),
    .wbs_we_i (wbs_we_i),
    .wbs_sel_i(wbs_sel_i),
    .wbs_adr_i(wbs_adr_i),
    .wbs_dat_i(wbs_dat_i),
    .wbs_ack_o(wbs_ack_o),
    .wbs_dat_o(wbs_dat_o),
    .s_cyc_o  (s_cyc_o),
    .s_stb_o  (s_stb_o),
    .s_we_o   (s_we_o),
    .s_sel_o  (s_sel_o),
    .s_adr_o  (s_adr_o),
    .s_dat_o  (s_dat_o),
    .s_dat_i  (s_dat_i),
    .s_ack_i  (s_ack_i),
    .irq      (irq)
  );

  typedef struct {
    logic [31:0] adr;
    logic        we;
    logic [31:0] wdat;
    logic [3:0]  sel;
    int          lat;      // slave ack delay after first strobe cycle, -1 = never
    logic [31:0] sdat;
    int          ack_k;    // cycle of upstream ack after request, 0 = none in 20
    logic        chk_rdat;
    logic [31:0] rdat;
    logic [3:0]  mask;     // slots that must see s_cyc_o
    int          stb_n;
    logic        irq;
    logic [7:0]  sadr;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic [31:0] adr, logic we, logic [31:0] wdat, logic [3:0] sel,
                              int lat, logic [31:0] sdat, int ack_k, logic chk_rdat,
                              logic [31:0] rdat, logic [3:0] mask, int stb_n, logic irq_e,
                              logic [7:0] sadr);
    vec_t v;
    v.adr = adr; v.we = we; v.wdat = wdat; v.sel = sel; v.lat = lat; v.sdat = sdat;
    v.ack_k = ack_k; v.chk_rdat = chk_rdat; v.rdat = rdat; v.mask = mask;
    v.stb_n = stb_n; v.irq = irq_e; v.sadr = sadr;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // One upstream transaction with a bench-side slave model; returns what was observed.
  task automatic xfer(input logic [31:0] adr, input logic we, input logic [31:0] wdat,
                      input logic [3:0] sel, input int lat, input logic [31:0] sdat,
                      output int ack_k, output logic [31:0] rdat, output logic [NS-1:0] cyc_seen,
                      output int stb_n, output logic [7:0] o_adr, output logic o_we,
                      output logic [3:0] o_sel, output logic [31:0] o_dat, output logic o_irq);
    ack_k = 0; rdat = '0; cyc_seen = '0; stb_n = 0;
    o_adr = '0; o_we = 1'b0; o_sel = '0; o_dat = '0; o_irq = 1'b0;
    wbs_adr_i = adr; wbs_we_i = we; wbs_dat_i = wdat; wbs_sel_i = sel;
    wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk); @(negedge clk);
      cyc_seen = cyc_seen | s_cyc_o;
      o_irq = irq;
      s_ack_i = '0;
      if (s_stb_o != '0) begin
        stb_n++;
        if (stb_n == 1) begin
          o_adr = s_adr_o; o_we = s_we_o; o_sel = s_sel_o; o_dat = s_dat_o;
        end
        if (lat >= 0 && stb_n == lat + 1) begin
          s_ack_i = s_stb_o;
          s_dat_i = {NS{sdat}};
        end
      end
      if (wbs_ack_o) begin
        ack_k = k;
        rdat = wbs_dat_o;
        break;
      end
    end
    wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0; wbs_we_i = 1'b0;
    s_ack_i = '0;
    @(posedge clk); @(negedge clk);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin
    int ack_k, stb_n, exp_cnt;
    logic [31:0] rdat, o_dat;
    logic [NS-1:0] cyc_seen;
    logic [7:0] o_adr;
    logic o_we, o_irq;
    logic [3:0] o_sel;
    localparam logic [31:0] C = 32'h3000_0400;

    vecs.push_back(mk(C + 32'h0,   0, 0, 4'hF, -1, 0, 2, 1, 32'h0000_000F, 4'b0000, 0, 0, 0));
    vecs.push_back(mk(C + 32'h4,   0, 0, 4'hF, -1, 0, 2, 1, 32'h0,         4'b0000, 0, 0, 0));
    vecs.push_back(mk(C + 32'h8,   0, 0, 4'hF, -1, 0, 2, 1, 32'h0,         4'b0000, 0, 0, 0));
    vecs.push_back(mk(C + 32'hC,   0, 0, 4'hF, -1, 0, 2, 1, 32'h0,         4'b0000, 0, 0, 0));
    vecs.push_back(mk(32'h3000_0204, 0, 0, 4'hF, 3, 32'h1234_5678, 5, 1, 32'h1234_5678, 4'b0100, 4, 0, 8'h04));
    vecs.push_back(mk(32'h3000_0010, 0, 0, 4'hF, 0, 32'hA5A5_0001, 2, 1, 32'hA5A5_0001, 4'b0001, 1, 0, 8'h10));
    vecs.push_back(mk(32'h3000_03FC, 1, 32'hCAFE_F00D, 4'b0011, 1, 0, 3, 0, 0, 4'b1000, 2, 0, 8'hFC));
    vecs.push_back(mk(C + 32'h8,   1, 32'h1, 4'b0001, -1, 0, 2, 0, 0,          4'b0000, 0, 0, 0));
    vecs.push_back(mk(C + 32'h8,   0, 0, 4'hF, -1, 0, 2, 1, 32'h1,         4'b0000, 0, 0, 0));
    vecs.push_back(mk(32'h3000_0100, 0, 0, 4'hF, -1, 0, 9, 1, 32'hDEAD_BEEF, 4'b0010, 8, 1, 8'h00));
    vecs.push_back(mk(C + 32'h4,   0, 0, 4'hF, -1, 0, 2, 1, 32'h101,       4'b0000, 0, 1, 0));
    vecs.push_back(mk(C + 32'h4,   1, 32'h1, 4'b0001, -1, 0, 2, 0, 0,          4'b0000, 0, 0, 0));
    vecs.push_back(mk(C + 32'h4,   0, 0, 4'hF, -1, 0, 2, 1, 32'h100,       4'b0000, 0, 0, 0));
    vecs.push_back(mk(32'h3000_0280, 0, 0, 4'hF, 7, 32'h7777_0007, 9, 1, 32'h7777_0007, 4'b0100, 8, 0, 8'h80));
    vecs.push_back(mk(C + 32'h4,   0, 0, 4'hF, -1, 0, 2, 1, 32'h100,       4'b0000, 0, 0, 0));
    vecs.push_back(mk(C + 32'h0,   1, 32'hE, 4'b0001, -1, 0, 2, 0, 0,          4'b0000, 0, 0, 0));
    vecs.push_back(mk(32'h3000_0000, 1, 32'h1111_1111, 4'hF, 0, 0, 1, 1, 32'h0, 4'b0000, 0, 0, 0));
    vecs.push_back(mk(32'h3000_0020, 0, 0, 4'hF, 0, 32'h5555_AAAA, 1, 1, 32'h0, 4'b0000, 0, 0, 0));
    vecs.push_back(mk(C + 32'h0,   0, 0, 4'hF, -1, 0, 2, 1, 32'hE,         4'b0000, 0, 0, 0));
    vecs.push_back(mk(C + 32'h0,   1, 32'hF, 4'b1110, -1, 0, 2, 0, 0,          4'b0000, 0, 0, 0));
    vecs.push_back(mk(C + 32'h0,   0, 0, 4'hF, -1, 0, 2, 1, 32'hE,         4'b0000, 0, 0, 0));
    vecs.push_back(mk(C + 32'h0,   1, 32'hF, 4'b0001, -1, 0, 2, 0, 0,          4'b0000, 0, 0, 0));
    vecs.push_back(mk(32'h3000_0600, 0, 0, 4'hF, 0, 32'h1, 0, 0, 0,          4'b0000, 0, 0, 0));
    vecs.push_back(mk(32'h2000_0000, 1, 32'h2, 4'hF, 0, 32'h1, 0, 0, 0,      4'b0000, 0, 0, 0));
    vecs.push_back(mk(C + 32'h0,   0, 0, 4'hF, -1, 0, 2, 1, 32'hF,         4'b0000, 0, 0, 0));
    vecs.push_back(mk(32'h3000_0104, 0, 0, 4'hF, 0, 32'h0BAD_CAFE, 2, 1, 32'h0BAD_CAFE, 4'b0010, 1, 0, 8'h04));

    rst = 1'b1; active = 1'b1;
    wbs_cyc_i = 0; wbs_stb_i = 0; wbs_we_i = 0; wbs_sel_i = 0; wbs_adr_i = 0; wbs_dat_i = 0;
    s_dat_i = '0; s_ack_i = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst.ack", 32'(wbs_ack_o), 0);
    chk("rst.dat", wbs_dat_o, 0);
    chk("rst.cyc", 32'(s_cyc_o), 0);
    chk("rst.stb", 32'(s_stb_o), 0);
    chk("rst.down", {s_we_o, s_sel_o, s_adr_o}, 0);
    chk("rst.sdat", s_dat_o, 0);
    chk("rst.irq", 32'(irq), 0);

    foreach (vecs[i]) begin
      xfer(vecs[i].adr, vecs[i].we, vecs[i].wdat, vecs[i].sel, vecs[i].lat, vecs[i].sdat,
           ack_k, rdat, cyc_seen, stb_n, o_adr, o_we, o_sel, o_dat, o_irq);
      chk($sformatf("v%0d.ack_k", i), 32'(ack_k), 32'(vecs[i].ack_k));
      chk($sformatf("v%0d.cyc", i), 32'(cyc_seen), 32'(vecs[i].mask));
      chk($sformatf("v%0d.stb_n", i), 32'(stb_n), 32'(vecs[i].stb_n));
      chk($sformatf("v%0d.irq", i), 32'(o_irq), 32'(vecs[i].irq));
      if (vecs[i].chk_rdat)
        chk($sformatf("v%0d.rdat", i), rdat, vecs[i].rdat);
      if (vecs[i].mask != 4'b0000) begin
        chk($sformatf("v%0d.s_adr", i), 32'(o_adr), 32'(vecs[i].sadr));
        chk($sformatf("v%0d.s_we", i), 32'(o_we), 32'(vecs[i].we));
        chk($sformatf("v%0d.s_sel", i), 32'(o_sel), 32'(vecs[i].sel));
        chk($sformatf("v%0d.s_dat", i), o_dat, vecs[i].wdat);
      end
    end

    // Abort by dropping active while slot 3 is being forwarded.
    wbs_adr_i = 32'h3000_0308; wbs_we_i = 1'b1; wbs_dat_i = 32'h1357_9BDF; wbs_sel_i = 4'hF;
    wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1;
    repeat (3) begin @(posedge clk); @(negedge clk); end
    chk("abort.cyc_before", 32'(s_cyc_o), 32'b1000);
    active = 1'b0;
    @(posedge clk); @(negedge clk);
    chk("abort.ack", 32'(wbs_ack_o), 0);
    chk("abort.dat", wbs_dat_o, 0);
    chk("abort.cyc", 32'(s_cyc_o), 0);
    chk("abort.stb", 32'(s_stb_o), 0);
    chk("abort.down", {s_we_o, s_sel_o, s_adr_o}, 0);
    chk("abort.sdat", s_dat_o, 0);
    chk("abort.irq", 32'(irq), 0);
    begin
      int acks = 0;
      repeat (10) begin
        @(posedge clk); @(negedge clk);
        if (wbs_ack_o || s_cyc_o != '0) acks++;
      end
      chk("abort.quiet", 32'(acks), 0);
    end
    wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0; wbs_we_i = 1'b0;
    active = 1'b1;
    @(posedge clk); @(negedge clk);
    xfer(32'h3000_0304, 0, 0, 4'hF, 1, 32'h2468_ACE0, ack_k, rdat, cyc_seen, stb_n,
         o_adr, o_we, o_sel, o_dat, o_irq);
    chk("post_abort.ack_k", 32'(ack_k), 3);
    chk("post_abort.rdat", rdat, 32'h2468_ACE0);
    chk("post_abort.cyc", 32'(cyc_seen), 32'b1000);
    xfer(C + 32'h4, 0, 0, 4'hF, -1, 0, ack_k, rdat, cyc_seen, stb_n, o_adr, o_we, o_sel, o_dat, o_irq);
    chk("post_abort.status", rdat, 32'h100);

    // Completed-transaction counter for slot 0; a timeout is not counted.
`ifdef WB_SLOT_TXN_COUNT_EN
    exp_cnt = 5;
`else
    exp_cnt = 0;
`endif
    xfer(C + 32'h10, 1, 32'h0, 4'hF, -1, 0, ack_k, rdat, cyc_seen, stb_n, o_adr, o_we, o_sel, o_dat, o_irq);
    for (int n = 0; n < 5; n++) begin
      xfer(32'h3000_0000 + 32'(4 * n), 0, 0, 4'hF, 0, 32'(n), ack_k, rdat, cyc_seen, stb_n,
           o_adr, o_we, o_sel, o_dat, o_irq);
      chk($sformatf("cnt.acc%0d", n), rdat, 32'(n));
    end
    xfer(32'h3000_0040, 0, 0, 4'hF, -1, 0, ack_k, rdat, cyc_seen, stb_n, o_adr, o_we, o_sel, o_dat, o_irq);
    chk("cnt.to_rdat", rdat, 32'hDEAD_BEEF);
    xfer(C + 32'h10, 0, 0, 4'hF, -1, 0, ack_k, rdat, cyc_seen, stb_n, o_adr, o_we, o_sel, o_dat, o_irq);
    chk("cnt.value", rdat, 32'(exp_cnt));
    xfer(C + 32'h10, 1, 32'h1234, 4'hF, -1, 0, ack_k, rdat, cyc_seen, stb_n, o_adr, o_we, o_sel, o_dat, o_irq);
    xfer(C + 32'h10, 0, 0, 4'hF, -1, 0, ack_k, rdat, cyc_seen, stb_n, o_adr, o_we, o_sel, o_dat, o_irq);
    chk("cnt.cleared", rdat, 0);
    xfer(C + 32'h4, 0, 0, 4'hF, -1, 0, ack_k, rdat, cyc_seen, stb_n, o_adr, o_we, o_sel, o_dat, o_irq);
    chk("cnt.status", rdat, 32'h001);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
